writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the core. Retires instructions from execute and drives the register file's single write port (write_en_rd / write_rd / write_val).
- ALU results pass through in one cycle.
- Loads wait for the data-memory response, then are byte/half selected and sign/zero extended before writing.
- Maintains the retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (reset==0 resets on the clk edge)
- ex_valid  in  1  execute presents a retiring instruction
- ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready
- ex_rd  in  5  destination register
- ex_is_load  in  1  instruction is a load; result comes from memory
- ex_funct3  in  3  load width/sign encoding (ignored when !ex_is_load)
- ex_addr_lo  in  2  load address bits [1:0]
- ex_result  in  32  ALU result (ignored for loads)
- mem_rsp_valid  in  1  load data valid this cycle
- mem_rsp_data  in  32  aligned 32-bit word containing the load data
- write_en_rd  out  1  register-file write strobe
- write_rd  out  5  register-file write address
- write_val  out  32  register-file write data
- instret  out  INSTRET_W  retired-instruction count
- rsp_unexpected  out  1  sticky: mem_rsp_valid seen while not in LOAD_WAIT

Behaviour:
- Reset values: write_en_rd=0, write_rd=0, write_val=0, instret=0, rsp_unexpected=0, state=IDLE. Reset mid-LOAD_WAIT abandons the load; a response arriving after reset is unexpected.
- States are IDLE and LOAD_WAIT. ex_ready = (state==IDLE), combinational from state only.
- IDLE, accept with !ex_is_load:
  - Next edge registers write_rd=ex_rd and write_val=ex_result.
  - write_en_rd=(ex_rd!=0) for exactly one cycle.
  - instret increments by 1. State stays IDLE.
  - Back-to-back ALU accepts every cycle are supported, giving a continuous write strobe.
- IDLE, accept with ex_is_load:
  - Latch rd, funct3 and addr_lo. Go to LOAD_WAIT.
  - The outputs' write_en_rd drops to 0 that edge, unless it is the tail of a prior ALU op already registered.
- LOAD_WAIT, mem_rsp_valid=1:
  - Next edge: write_val=extracted data, write_rd=latched rd, write_en_rd=(rd!=0) for one cycle, instret+1, state to IDLE.
  - A new accept is possible in the cycle after the return to IDLE.
- LOAD_WAIT, mem_rsp_valid=0: hold state; write_en_rd=0. There is no timeout.
- mem_rsp_valid in IDLE: data is ignored and rsp_unexpected sets. It clears only on reset.
- Load extraction:
  - funct3=0 (LB): byte at addr_lo, sign-extended.
  - funct3=4 (LBU): byte at addr_lo, zero-extended.
  - funct3=1 (LH): half at addr_lo[1], sign-extended; addr_lo[0] ignored.
  - funct3=5 (LHU): half at addr_lo[1], zero-extended; addr_lo[0] ignored.
  - funct3=2 (LW) and reserved codes 3, 6, 7: full word, addr_lo ignored.
- rd==0: no write strobe, but instret still counts the retirement.
- instret wraps modulo 2^INSTRET_W.
- write_en_rd is never asserted for more than one cycle per retired instruction. It is never asserted in the cycle after reset deasserts.

Decomposition:
- Shared package (core_pkg) holds:
  - LOAD_B/H/W/BU/HU funct3 localparams
  - wb_state_t enum {WB_IDLE, WB_LOAD_WAIT}
  - XLEN constant
- Sub-module load_align: purely combinational (word, funct3, addr_lo) -> 32-bit extended value. Instantiated once and unit-tested separately.

Test Plan:
- ALU path: reset, then accept rd=5, result=0x12345678 -> next cycle write_en_rd=1, write_rd=5, write_val=0x12345678, instret=1; the following cycle write_en_rd=0.
- Back-to-back: three ALU accepts rd=1,2,0 on consecutive cycles -> strobes on rd=1 and rd=2 only, write_en_rd low for rd=0, instret=3.
- Loads, each with mem_rsp_data=0xA1B2C3F4:
  - LB with addr_lo=0 -> write_val=0xFFFFFFF4.
  - LBU with addr_lo=2 -> 0x000000B2.
  - LH with addr_lo=2 -> 0xFFFFA1B2.
  - LHU with addr_lo=3 -> 0x0000A1B2.
  - LW -> 0xA1B2C3F4.
  - ex_ready=0 throughout the wait.
- Load stall: accept LW rd=7, hold mem_rsp_valid low 4 cycles -> no strobe and ex_ready=0 for all 4; assert rsp -> one strobe rd=7, then ex_ready=1.
- Reset mid-load: accept load, drive reset=0 for one edge in LOAD_WAIT -> state IDLE, instret=0, no strobe; a subsequent mem_rsp_valid sets rsp_unexpected=1 with no write.
- Unexpected response: mem_rsp_valid=1 in IDLE after reset -> rsp_unexpected=1 and stays set, write_en_rd=0, instret unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core back end: load encodings, writeback FSM states, datapath width.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LOAD_B  = 3'd0;
    localparam logic [2:0] LOAD_H  = 3'd1;
    localparam logic [2:0] LOAD_W  = 3'd2;
    localparam logic [2:0] LOAD_BU = 3'd4;
    localparam logic [2:0] LOAD_HU = 3'd5;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_LOAD_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load data extraction: selects byte/half/word from an aligned word and extends it.
module load_align
    import core_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            LOAD_B:  o_data = {{24{w_byte[7]}}, w_byte};
            LOAD_BU: o_data = {24'd0, w_byte};
            LOAD_H:  o_data = {{16{w_half[15]}}, w_half};
            LOAD_HU: o_data = {16'd0, w_half};
            // LW and the reserved encodings all return the full word
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results in one cycle, waits for load data, drives the RF write port.
module writeback_stage
    import core_pkg::*;
#(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_is_load,
    input  logic [2:0]           ex_funct3,
    input  logic [1:0]           ex_addr_lo,
    input  logic [XLEN-1:0]      ex_result,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rsp_data,
    output logic                 write_en_rd,
    output logic [4:0]           write_rd,
    output logic [XLEN-1:0]      write_val,
    output logic [INSTRET_W-1:0] instret,
    output logic                 rsp_unexpected
);

    wb_state_t             r_state;
    wb_state_t             w_state_nxt;
    logic [4:0]            r_ld_rd;
    logic [2:0]            r_ld_funct3;
    logic [1:0]            r_ld_addr_lo;
    logic [XLEN-1:0]       w_ld_data;
    logic                  w_accept;
    logic                  w_retire_alu;
    logic                  w_retire_load;

    load_align u_load_align (
        .i_word    (mem_rsp_data),
        .i_funct3  (r_ld_funct3),
        .i_addr_lo (r_ld_addr_lo),
        .o_data    (w_ld_data)
    );

    assign ex_ready      = (r_state == WB_IDLE);
    assign w_accept      = ex_valid && ex_ready;
    assign w_retire_alu  = w_accept && !ex_is_load;
    assign w_retire_load = (r_state == WB_LOAD_WAIT) && mem_rsp_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WB_IDLE:      if (w_accept && ex_is_load) w_state_nxt = WB_LOAD_WAIT;
            WB_LOAD_WAIT: if (mem_rsp_valid)          w_state_nxt = WB_IDLE;
            default:      w_state_nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= WB_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Load context is data only; it is always rewritten before use
    always_ff @(posedge clk) begin
        if (w_accept && ex_is_load) begin
            r_ld_rd      <= ex_rd;
            r_ld_funct3  <= ex_funct3;
            r_ld_addr_lo <= ex_addr_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            write_en_rd    <= 1'b0;
            write_rd       <= 5'd0;
            write_val      <= '0;
            instret        <= '0;
            rsp_unexpected <= 1'b0;
        end else begin
            write_en_rd <= 1'b0;
            if (w_retire_alu) begin
                write_en_rd <= (ex_rd != 5'd0);
                write_rd    <= ex_rd;
                write_val   <= ex_result;
                instret     <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
            end else if (w_retire_load) begin
                write_en_rd <= (r_ld_rd != 5'd0);
                write_rd    <= r_ld_rd;
                write_val   <= w_ld_data;
                instret     <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
            end
            if (mem_rsp_valid && (r_state == WB_IDLE))
                rsp_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized scoreboard bench for writeback_stage against a byte-level load/retire model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic [31:0] ex_result;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        write_en_rd;
    logic [4:0]  write_rd;
    logic [31:0] write_val;
    logic [63:0] instret;
    logic        rsp_unexpected;

    writeback_stage #(.INSTRET_W(64)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
        .ex_addr_lo(ex_addr_lo), .ex_result(ex_result),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .write_en_rd(write_en_rd), .write_rd(write_rd), .write_val(write_val),
        .instret(instret), .rsp_unexpected(rsp_unexpected)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];
    longint unsigned exp_instret = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input int f3, input int addr);
        int unsigned bytes[4];
        int unsigned v;
        for (int i = 0; i < 4; i++) bytes[i] = (word >> (8 * i)) & 32'hFF;
        case (f3)
            0, 4: begin
                v = bytes[addr];
                if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            1, 5: begin
                v = bytes[(addr / 2) * 2] + 256 * bytes[(addr / 2) * 2 + 1];
                if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (write_en_rd) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe: unexpected write rd=%0d val=0x%0h at %0t", write_rd, write_val, $time);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("write_rd", 64'(write_rd), 64'(e[36:32]));
                check("write_val", 64'(write_val), 64'(e[31:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_beat(input logic [4:0] rd, input logic [31:0] val);
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = rd; ex_result = val;
        ex_funct3 = 3'($urandom); ex_addr_lo = 2'($urandom);
        if (rd != 0) exp_q.push_back({rd, val});
        exp_instret++;
        tick();
    endtask

    task automatic load_accept(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; ex_funct3 = f3; ex_addr_lo = a;
        ex_result = $urandom;
        tick();
        ex_valid = 1'b0;
        check("ready_in_wait", 64'(ex_ready), 64'd0);
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                           input logic [31:0] word, input int stall);
        load_accept(rd, f3, a);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("ready_stall", 64'(ex_ready), 64'd0);
            check("wen_stall", 64'(write_en_rd), 64'd0);
        end
        if (rd != 0) exp_q.push_back({rd, model_load(word, int'(f3), int'(a))});
        exp_instret++;
        mem_rsp_valid = 1'b1; mem_rsp_data = word;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
        check("ready_after_load", 64'(ex_ready), 64'd1);
        check("instret_load", instret, exp_instret);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        exp_instret = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_funct3 = 0; ex_addr_lo = 0;
        ex_result = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        apply_reset();
        check("rst_wen", 64'(write_en_rd), 64'd0);
        check("rst_rd", 64'(write_rd), 64'd0);
        check("rst_val", 64'(write_val), 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_unexp", 64'(rsp_unexpected), 64'd0);
        check("rst_ready", 64'(ex_ready), 64'd1);

        alu_beat(5'd5, 32'h1234_5678);
        ex_valid = 1'b0;
        check("alu_wen", 64'(write_en_rd), 64'd1);
        check("alu_instret", instret, 64'd1);
        tick();
        check("alu_wen_drop", 64'(write_en_rd), 64'd0);

        apply_reset();
        alu_beat(5'd1, 32'hAAAA_0001);
        alu_beat(5'd2, 32'hBBBB_0002);
        alu_beat(5'd0, 32'hCCCC_0003);
        ex_valid = 1'b0;
        check("b2b_wen_rd0", 64'(write_en_rd), 64'd0);
        check("b2b_instret", instret, 64'd3);

        do_load(5'd3, 3'd0, 2'd0, 32'hA1B2_C3F4, 0);
        do_load(5'd4, 3'd4, 2'd2, 32'hA1B2_C3F4, 1);
        do_load(5'd6, 3'd1, 2'd2, 32'hA1B2_C3F4, 0);
        do_load(5'd8, 3'd5, 2'd3, 32'hA1B2_C3F4, 2);
        do_load(5'd9, 3'd2, 2'd1, 32'hA1B2_C3F4, 0);
        do_load(5'd7, 3'd2, 2'd0, 32'h0BAD_F00D, 4);
        check("unexp_clean", 64'(rsp_unexpected), 64'd0);

        load_accept(5'd10, 3'd2, 2'd0);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_instret = 0;
        check("midrst_ready", 64'(ex_ready), 64'd1);
        check("midrst_instret", instret, 64'd0);
        check("midrst_wen", 64'(write_en_rd), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        check("late_rsp_unexp", 64'(rsp_unexpected), 64'd1);
        check("late_rsp_wen", 64'(write_en_rd), 64'd0);
        check("late_rsp_instret", instret, 64'd0);
        tick();
        tick();
        check("unexp_sticky", 64'(rsp_unexpected), 64'd1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_load(5'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom_range(0, 3));
            end else begin
                alu_beat(5'($urandom), $urandom);
                if ($urandom_range(0, 1) == 0) begin
                    ex_valid = 1'b0;
                    tick();
                end
            end
        end
        ex_valid = 1'b0;
        tick();
        tick();
        check("rand_instret", instret, exp_instret);
        check("rand_ready", 64'(ex_ready), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
